inst_rom_loader: RTL and testbench

//  Instruction-memory responder for the core's fetch port (rom_ce/rom_addr -> rom_data).

---
 rtl/inst_rom_loader.sv | 145 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
`default_nettype none
// inst_rom_loader: combinational instruction ROM for the fetch port, filled through a
// byte-serial valid/ready loader (big-endian words) that stalls the core while it runs.
module inst_rom_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_ce_i,
   input  logic [31:0]       rom_addr_i,
   output logic [31:0]       rom_data_o,
   input  logic              ld_start_i,
   input  logic [ADDR_W:0]   ld_len_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   output logic              ld_ready_o,
   output logic              ld_done_o,
   output logic              busy_o,
   output logic              addr_err_o
);

   localparam int              DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [ADDR_W:0]   ptr;
   logic [ADDR_W:0]   ptr_inc;
   logic [ADDR_W:0]   len;
   logic [1:0]        bcnt;
   logic [23:0]       shbuf;
   logic              zero_done;
   logic              start_ok;
   logic              start_zero;
   logic              accept;
   logic              wr_en;
   logic              fetch_hi_ok;
   logic              fetch_bad;

   logic [31:0]       mem [DEPTH];

   assign ptr_inc = ptr + PTR_ONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      start_ok   = 1'b0;
      start_zero = 1'b0;
      accept     = 1'b0;
      wr_en      = 1'b0;
      ld_ready_o = 1'b0;
      busy_o     = 1'b0;
      ld_done_o  = zero_done;
      case (state)
         IDLE: begin
            if (ld_start_i) begin
               if (ld_len_i != '0) begin
                  start_ok  = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  start_zero = 1'b1;
               end
            end
         end
         LOAD: begin
            ld_ready_o = 1'b1;
            busy_o     = 1'b1;
            accept     = ld_valid_i;
            if (ld_valid_i && (bcnt == 2'd3)) begin
               wr_en = 1'b1;
               if (ptr_inc == len) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            busy_o    = 1'b1;
            ld_done_o = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Loader datapath; shbuf keeps the three most recent bytes of the word in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr        <= '0;
         len        <= '0;
         bcnt       <= 2'd0;
         shbuf      <= 24'h0;
         zero_done  <= 1'b0;
         addr_err_o <= 1'b0;
      end else begin
         zero_done <= start_zero;
         if (start_ok) begin
            ptr   <= '0;
            bcnt  <= 2'd0;
            shbuf <= 24'h0;
            len   <= (ld_len_i > DEPTH_LEN) ? DEPTH_LEN : ld_len_i;
         end else if (accept) begin
            shbuf <= {shbuf[15:0], ld_byte_i};
            bcnt  <= bcnt + 2'd1;
            if (wr_en) begin
               ptr <= ptr_inc;
            end
         end
         // A new load wipes the error flag even if a bad fetch lands on the same edge.
         if (start_ok) begin
            addr_err_o <= 1'b0;
         end else if (fetch_bad) begin
            addr_err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr[ADDR_W-1:0]] <= {shbuf, ld_byte_i};
      end
   end

   assign fetch_hi_ok = (rom_addr_i[31:ADDR_W+2] == '0);
   assign fetch_bad   = rom_ce_i && !busy_o && (!fetch_hi_ok || (rom_addr_i[1:0] != 2'b00));
   assign rom_data_o  = (rom_ce_i && !busy_o && fetch_hi_ok) ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// tb_inst_rom_loader: directed and randomized checks of fetch, load handshake and errors
// against a word-level memory model built from the byte stream.
module tb_inst_rom_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic              clk = 1'b0;
   logic              rst;
   logic              rom_ce;
   logic [31:0]       rom_addr;
   logic [31:0]       rom_data;
   logic              ld_start;
   logic [ADDR_W:0]   ld_len;
   logic              ld_valid;
   logic [7:0]        ld_byte;
   logic              ld_ready;
   logic              ld_done;
   logic              busy;
   logic              addr_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] model_mem [DEPTH];
   int          m_bytes;
   logic [31:0] m_word;
   logic [7:0]  byte_q [$];

   inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_ce_i   (rom_ce),
      .rom_addr_i (rom_addr),
      .rom_data_o (rom_data),
      .ld_start_i (ld_start),
      .ld_len_i   (ld_len),
      .ld_valid_i (ld_valid),
      .ld_byte_i  (ld_byte),
      .ld_ready_o (ld_ready),
      .ld_done_o  (ld_done),
      .busy_o     (busy),
      .addr_err_o (addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [ADDR_W:0] len);
      ld_start = 1'b1;
      ld_len   = len;
      step();
      ld_start = 1'b0;
      m_bytes  = 0;
      m_word   = 32'h0;
      check("start_busy", busy, 1);
      check("start_ready", ld_ready, 1);
      check("start_err_clear", addr_err, 0);
   endtask

   // mode 0: valid every cycle, 1: alternating, 2: random gaps
   task automatic feed(input int nb, input int mode, input bit poke_start);
      int acc = 0;
      int cyc = 0;
      while (acc < nb && cyc < 20000) begin
         bit v;
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         ld_valid = v;
         if (v && byte_q.size() > 0) ld_byte = byte_q.pop_front();
         else                        ld_byte = 8'($urandom);
         ld_start = poke_start && !v;
         ld_len   = 11'd5;
         #1;
         check("feed_ready", ld_ready, 1);
         check("feed_no_done", ld_done, 0);
         step();
         if (v) begin
            acc++;
            m_bytes++;
            m_word = (m_word << 8) | {24'h0, ld_byte};
            if (m_bytes % 4 == 0) model_mem[m_bytes / 4 - 1] = m_word;
         end
         cyc++;
      end
      ld_valid = 1'b0;
      ld_start = 1'b0;
      if (acc < nb) check("feed_timeout", acc, nb);
   endtask

   task automatic expect_done();
      check("done_pulse", ld_done, 1);
      check("done_busy", busy, 1);
      check("done_ready_low", ld_ready, 0);
      step();
      check("done_clear", ld_done, 0);
      check("idle_busy_low", busy, 0);
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
      rom_ce   = 1'b1;
      rom_addr = a;
      #1;
      check(tag, rom_data, exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; rom_ce = 1'b0; rom_addr = 32'h0; ld_start = 1'b0;
      ld_len = '0; ld_valid = 1'b0; ld_byte = 8'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rom_data", rom_data, 0);
      check("rst_ready", ld_ready, 0);
      check("rst_done", ld_done, 0);
      check("rst_busy", busy, 0);
      check("rst_err", addr_err, 0);
      rst = 1'b1;
      step();

      // directed two-word load
      byte_q = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
      start_load(11'd2);
      feed(8, 0, 1'b0);
      expect_done();
      fetch(32'h4, 32'h34030002, "fetch_w1");
      fetch(32'h0, 32'h34020001, "fetch_w0");
      rom_ce = 1'b0;
      step();
      check("no_err_aligned", addr_err, 0);

      // gapped single-word load with start pokes during LOAD
      start_load(11'd1);
      fetch(32'h0, 32'h0, "busy_fetch_nop");
      rom_ce = 1'b0;
      feed(4, 1, 1'b1);
      expect_done();
      fetch(32'h0, model_mem[0], "gap_w0");
      fetch(32'h4, 32'h34030002, "gap_w1_kept");
      rom_ce = 1'b0;

      // out-of-range and misaligned fetches
      fetch(32'h0000_1000, 32'h0, "oor_nop");
      step();
      rom_ce = 1'b0;
      check("oor_err", addr_err, 1);
      step();
      check("err_sticky", addr_err, 1);
      start_load(11'd1);
      feed(4, 2, 1'b0);
      expect_done();
      fetch(32'h2, model_mem[0], "misaligned_data");
      step();
      rom_ce = 1'b0;
      check("misaligned_err", addr_err, 1);

      // oversize length clamps to DEPTH words
      start_load(11'h7FF);
      feed(4 * DEPTH, 0, 1'b0);
      expect_done();
      for (int i = 0; i < DEPTH; i++) begin
         fetch(32'(i * 4), model_mem[i], "clamp_readback");
         step();
      end
      rom_ce = 1'b0;
      check("readback_no_err", addr_err, 0);

      // random short loads with random gaps
      repeat (4) begin
         int n;
         n = $urandom_range(1, 6);
         start_load(11'(n));
         feed(4 * n, 2, 1'b0);
         expect_done();
      end
      for (int i = 0; i < 8; i++) begin
         fetch(32'(i * 4), model_mem[i], "rand_readback");
         step();
      end
      rom_ce = 1'b0;

      // asynchronous reset in the middle of a load
      start_load(11'd2);
      feed(6, 0, 1'b0);
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_ready", ld_ready, 0);
      check("midrst_done", ld_done, 0);
      check("midrst_err", addr_err, 0);
      step();
      rst = 1'b1;
      step();
      check("post_rst_busy", busy, 0);
      fetch(32'h0, model_mem[0], "rst_kept_w0");
      fetch(32'h4, model_mem[1], "rst_kept_w1");
      rom_ce = 1'b0;

      // zero-length start: single done pulse, stays idle
      ld_start = 1'b1;
      ld_len   = '0;
      step();
      ld_start = 1'b0;
      check("zero_done", ld_done, 1);
      check("zero_busy", busy, 0);
      check("zero_ready", ld_ready, 0);
      step();
      check("zero_done_clear", ld_done, 0);
      check("zero_ready_idle", ld_ready, 0);

      // fresh load after the reset; partial word must not leak in
      start_load(11'd1);
      feed(4, 0, 1'b0);
      expect_done();
      fetch(32'h0, model_mem[0], "fresh_w0");
      rom_ce = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
